mem_shuffle_ctrl: RTL and testbench

MEM_SHUFFLE_CTRL -- requirements
Module: mem_shuffle_ctrl

---
 rtl/mem_shuffle_ctrl_if.sv | 47 ++++
 rtl/mem_shuffle_ctrl.sv | 99 +++++++++
 tb/tb_mem_shuffle_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_shuffle_ctrl_if.sv
// Shared types for the vector load path, plus the bundle of handshake/bus
// signals that connects the shuffle controller to its environment.
package core_pkg;
    localparam int unsigned NrLane = 4;
    typedef logic [63:0] vrf_data_t;
    typedef logic [7:0]  vrf_strb_t;
    typedef logic [15:0] vlen_t;
    typedef enum logic [1:0] {EW8, EW16, EW32, EW64} vew_e;
endpackage

interface mem_shuffle_ctrl_if #(
    parameter int unsigned NrLane = core_pkg::NrLane
) ();
    logic                                  req_valid_i;
    logic                                  req_ready_o;
    core_pkg::vlen_t                       req_bytes_i;
    core_pkg::vew_e                        req_sew_i;
    logic                                  mem_valid_i;
    logic                                  mem_ready_o;
    core_pkg::vrf_data_t [NrLane-1:0]      mem_data_i;
    core_pkg::vrf_data_t [NrLane-1:0]      shuf_data_o;
    core_pkg::vlen_t                       shuf_bytes_cnt_o;
    core_pkg::vew_e                        shuf_sew_o;
    core_pkg::vrf_data_t [NrLane-1:0]      shuf_data_i;
    core_pkg::vrf_strb_t [NrLane-1:0]      shuf_mask_i;
    logic                                  wb_valid_o;
    logic                                  wb_ready_i;
    core_pkg::vrf_data_t [NrLane-1:0]      wb_data_o;
    core_pkg::vrf_strb_t [NrLane-1:0]      wb_strb_o;
    logic                                  wb_last_o;
    logic                                  busy_o;
    logic                                  done_o;

    modport master (
        input  req_valid_i, req_bytes_i, req_sew_i, mem_valid_i, mem_data_i,
               shuf_data_i, shuf_mask_i, wb_ready_i,
        output req_ready_o, mem_ready_o, shuf_data_o, shuf_bytes_cnt_o, shuf_sew_o,
               wb_valid_o, wb_data_o, wb_strb_o, wb_last_o, busy_o, done_o
    );

    modport slave (
        output req_valid_i, req_bytes_i, req_sew_i, mem_valid_i, mem_data_i,
               shuf_data_i, shuf_mask_i, wb_ready_i,
        input  req_ready_o, mem_ready_o, shuf_data_o, shuf_bytes_cnt_o, shuf_sew_o,
               wb_valid_o, wb_data_o, wb_strb_o, wb_last_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_shuffle_ctrl.sv
// Streams memory beats of a load request through an external byte shuffler
// into a one-entry write-back register, one beat per cycle when unstalled.
module mem_shuffle_ctrl #(
    parameter int unsigned NrLane = core_pkg::NrLane
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_shuffle_ctrl_if.master bus
);
    localparam core_pkg::vlen_t ByteBlock = core_pkg::vlen_t'(NrLane * 8);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                                state_q, state_d;
    core_pkg::vlen_t                       remaining_q, beat_bytes;
    core_pkg::vew_e                        sew_q;
    logic                                  wb_valid_q, wb_last_q, done_q, done_d;
    core_pkg::vrf_data_t [NrLane-1:0]      wb_data_q;
    core_pkg::vrf_strb_t [NrLane-1:0]      wb_strb_q;
    logic                                  req_hs, mem_hs, wb_hs, mem_ready;

    always_comb begin
        beat_bytes = (remaining_q < ByteBlock) ? remaining_q : ByteBlock;
        // A beat may enter only if the output slot is empty or draining now.
        mem_ready  = (state_q == BUSY) && (remaining_q != '0) &&
                     (!wb_valid_q || bus.wb_ready_i);
        req_hs     = (state_q == IDLE) && bus.req_valid_i;
        mem_hs     = mem_ready && bus.mem_valid_i;
        wb_hs      = wb_valid_q && bus.wb_ready_i;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    if (bus.req_bytes_i == '0) done_d  = 1'b1;
                    else                       state_d = BUSY;
                end
            end
            BUSY: begin
                if (wb_hs && wb_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            remaining_q <= '0;
            sew_q       <= core_pkg::EW8;
            wb_valid_q  <= 1'b0;
            wb_last_q   <= 1'b0;
            wb_data_q   <= '0;
            wb_strb_q   <= '0;
        end else begin
            if (req_hs && bus.req_bytes_i != '0) begin
                remaining_q <= bus.req_bytes_i;
                sew_q       <= bus.req_sew_i;
            end
            if (mem_hs) begin
                remaining_q <= remaining_q - beat_bytes;
                wb_valid_q  <= 1'b1;
                wb_last_q   <= (remaining_q <= ByteBlock);
                wb_data_q   <= bus.shuf_data_i;
                wb_strb_q   <= bus.shuf_mask_i;
            end else if (wb_hs) begin
                wb_valid_q  <= 1'b0;
                wb_last_q   <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o      = (state_q == IDLE);
    assign bus.busy_o           = (state_q == BUSY);
    assign bus.mem_ready_o      = mem_ready;
    assign bus.done_o           = done_q;
    assign bus.shuf_data_o      = bus.mem_data_i;
    assign bus.shuf_bytes_cnt_o = beat_bytes;
    assign bus.shuf_sew_o       = sew_q;
    assign bus.wb_valid_o       = wb_valid_q;
    assign bus.wb_data_o        = wb_data_q;
    assign bus.wb_strb_o        = wb_strb_q;
    assign bus.wb_last_o        = wb_last_q;
endmodule

// File: tb/tb_mem_shuffle_ctrl.sv
// Directed bench for mem_shuffle_ctrl with a behavioural byte shuffler
// (data inverted, mask = low shuf_bytes_cnt bytes).
module tb_mem_shuffle_ctrl;
    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [255:0] d [8];
    logic [31:0]  m;

    mem_shuffle_ctrl_if #(.NrLane(4)) bus ();

    mem_shuffle_ctrl #(.NrLane(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // shuffler model
    always_comb begin
        bus.shuf_data_i = ~bus.shuf_data_o;
        if (bus.shuf_bytes_cnt_o >= 16'd32) m = 32'hFFFF_FFFF;
        else m = (32'd1 << bus.shuf_bytes_cnt_o) - 32'd1;
        bus.shuf_mask_i = m;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " wb_valid"},  256'(bus.wb_valid_o), 256'(0));
        chk({tag, " wb_data"},   256'(bus.wb_data_o), 256'(0));
        chk({tag, " wb_strb"},   256'(bus.wb_strb_o), 256'(0));
        chk({tag, " wb_last"},   256'(bus.wb_last_o), 256'(0));
        chk({tag, " done"},      256'(bus.done_o), 256'(0));
        chk({tag, " busy"},      256'(bus.busy_o), 256'(0));
        chk({tag, " mem_ready"}, 256'(bus.mem_ready_o), 256'(0));
        chk({tag, " req_ready"}, 256'(bus.req_ready_o), 256'(1));
        chk({tag, " sew"},       256'(bus.shuf_sew_o), 256'(core_pkg::EW8));
    endtask

    task automatic send_req(input logic [15:0] bytes, input core_pkg::vew_e sew);
        bus.req_valid_i = 1'b1;
        bus.req_bytes_i = bytes;
        bus.req_sew_i   = sew;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) d[i] = {8{32'(32'hA5C3_0000 + 32'(i * 32'h0101))}};
        rst_i = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_bytes_i = '0;
        bus.req_sew_i   = core_pkg::EW8;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;
        bus.wb_ready_i  = 1'b0;
        step(); step(); mid();
        chk_reset_vals("rst");
        step();
        rst_i = 1'b0;

        // 64B EW8, two back-to-back beats
        send_req(16'd64, core_pkg::EW8);
        mid();
        chk("a req_ready", 256'(bus.req_ready_o), 256'(1));
        chk("a mem_ready idle", 256'(bus.mem_ready_o), 256'(0));
        step();
        bus.req_valid_i = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = d[0];
        bus.wb_ready_i  = 1'b1;
        mid();
        chk("a busy", 256'(bus.busy_o), 256'(1));
        chk("a req_ready busy", 256'(bus.req_ready_o), 256'(0));
        chk("a mem_ready", 256'(bus.mem_ready_o), 256'(1));
        chk("a cnt0", 256'(bus.shuf_bytes_cnt_o), 256'(32));
        chk("a wb_valid pre", 256'(bus.wb_valid_o), 256'(0));
        step();
        bus.mem_data_i = d[1];
        mid();
        chk("a wb0 valid", 256'(bus.wb_valid_o), 256'(1));
        chk("a wb0 data", bus.wb_data_o, ~d[0]);
        chk("a wb0 strb", 256'(bus.wb_strb_o), 256'(32'hFFFF_FFFF));
        chk("a wb0 last", 256'(bus.wb_last_o), 256'(0));
        chk("a mem_ready 2", 256'(bus.mem_ready_o), 256'(1));
        step();
        bus.mem_valid_i = 1'b0;
        mid();
        chk("a wb1 data", bus.wb_data_o, ~d[1]);
        chk("a wb1 last", 256'(bus.wb_last_o), 256'(1));
        chk("a mem_ready drained", 256'(bus.mem_ready_o), 256'(0));
        chk("a done early", 256'(bus.done_o), 256'(0));
        step(); mid();
        chk("a done", 256'(bus.done_o), 256'(1));
        chk("a wb_valid end", 256'(bus.wb_valid_o), 256'(0));
        chk("a busy end", 256'(bus.busy_o), 256'(0));
        step(); mid();
        chk("a done pulse", 256'(bus.done_o), 256'(0));
        step();

        // 40B EW32, partial tail beat
        send_req(16'd40, core_pkg::EW32);
        step();
        bus.req_valid_i = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = d[2];
        mid();
        chk("b cnt0", 256'(bus.shuf_bytes_cnt_o), 256'(32));
        chk("b sew", 256'(bus.shuf_sew_o), 256'(core_pkg::EW32));
        step();
        bus.mem_data_i = d[3];
        mid();
        chk("b cnt1", 256'(bus.shuf_bytes_cnt_o), 256'(8));
        chk("b wb0 data", bus.wb_data_o, ~d[2]);
        chk("b wb0 last", 256'(bus.wb_last_o), 256'(0));
        step();
        bus.mem_valid_i = 1'b0;
        mid();
        chk("b wb1 data", bus.wb_data_o, ~d[3]);
        chk("b wb1 strb", 256'(bus.wb_strb_o), 256'(32'h0000_00FF));
        chk("b wb1 last", 256'(bus.wb_last_o), 256'(1));
        step(); mid();
        chk("b done", 256'(bus.done_o), 256'(1));
        step();

        // 64B with a 5-cycle write-back stall after the first beat
        send_req(16'd64, core_pkg::EW16);
        step();
        bus.req_valid_i = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = d[4];
        bus.wb_ready_i  = 1'b1;
        step();
        bus.mem_data_i = d[5];
        bus.wb_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("c stall mem_ready", 256'(bus.mem_ready_o), 256'(0));
            chk("c stall data", bus.wb_data_o, ~d[4]);
            chk("c stall valid", 256'(bus.wb_valid_o), 256'(1));
            chk("c stall cnt", 256'(bus.shuf_bytes_cnt_o), 256'(32));
            if (i < 4) step();
        end
        step();
        bus.wb_ready_i = 1'b1;
        mid();
        chk("c resume mem_ready", 256'(bus.mem_ready_o), 256'(1));
        step();
        bus.mem_valid_i = 1'b0;
        mid();
        chk("c wb1 data", bus.wb_data_o, ~d[5]);
        chk("c wb1 last", 256'(bus.wb_last_o), 256'(1));
        step(); mid();
        chk("c done", 256'(bus.done_o), 256'(1));
        chk("c no dup", 256'(bus.wb_valid_o), 256'(0));
        step();

        // zero-byte request
        send_req(16'd0, core_pkg::EW8);
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = d[6];
        mid();
        chk("d mem_ready req", 256'(bus.mem_ready_o), 256'(0));
        step();
        bus.req_valid_i = 1'b0;
        mid();
        chk("d done", 256'(bus.done_o), 256'(1));
        chk("d busy", 256'(bus.busy_o), 256'(0));
        chk("d mem_ready", 256'(bus.mem_ready_o), 256'(0));
        step(); mid();
        chk("d done pulse", 256'(bus.done_o), 256'(0));
        chk("d wb_valid", 256'(bus.wb_valid_o), 256'(0));
        step();
        bus.mem_valid_i = 1'b0;

        // reset mid-request with a pending write-back, then a 32B request
        send_req(16'd64, core_pkg::EW64);
        step();
        bus.req_valid_i = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = d[6];
        bus.wb_ready_i  = 1'b0;
        step();
        bus.mem_valid_i = 1'b0;
        mid();
        chk("e wb pending", 256'(bus.wb_valid_o), 256'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk_reset_vals("e async");
        step();
        rst_i = 1'b0;
        bus.wb_ready_i = 1'b1;
        mid();
        chk("e post wb_valid", 256'(bus.wb_valid_o), 256'(0));
        chk("e post busy", 256'(bus.busy_o), 256'(0));
        step();
        send_req(16'd32, core_pkg::EW8);
        step();
        bus.req_valid_i = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.mem_data_i  = d[7];
        mid();
        chk("e cnt", 256'(bus.shuf_bytes_cnt_o), 256'(32));
        chk("e mem_ready", 256'(bus.mem_ready_o), 256'(1));
        step();
        bus.mem_valid_i = 1'b0;
        mid();
        chk("e wb data", bus.wb_data_o, ~d[7]);
        chk("e wb strb", 256'(bus.wb_strb_o), 256'(32'hFFFF_FFFF));
        chk("e wb last", 256'(bus.wb_last_o), 256'(1));
        step(); mid();
        chk("e done", 256'(bus.done_o), 256'(1));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
